noise_stream_reader: RTL

Consumer end of the packed per-neuron noise bus produced by the LFSR noise generator bank. On a sample request it snapshots the full noise_array. It then streams one scaled, saturated noise word per neuron over a valid/ready interface to the time-multiplexed neuron update datapath. Sample requests that arrive while a stream is in progress are counted as drops.

---
 rtl/noise_stream_reader_pkg.sv | 19 +
 rtl/noise_scale_sat.sv | 31 +++
 rtl/noise_stream_reader.sv | 117 +++++++++++
 3 files changed

// File: rtl/noise_stream_reader_pkg.sv
// Shared types and defaults for the noise stream reader.
// Defaults track the LFSR noise generator bank that drives noise_array.
package noise_stream_reader_pkg;

    localparam int DEF_BUFFER_SIZE = 32;
    localparam int DEF_NUM_NEURONS = 16;
    localparam int DROP_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/noise_scale_sat.sv
// Arithmetic right shift of one signed noise word, then saturation
// to the signed OUT_W output range.
module noise_scale_sat
    import noise_stream_reader_pkg::*;
#(
    parameter int buffer_size = DEF_BUFFER_SIZE,
    parameter int OUT_W       = 16,
    parameter int SHIFT_W     = 5
) (
    input  logic [buffer_size-1:0] word_i,
    input  logic [SHIFT_W-1:0]     shift_i,
    output logic [OUT_W-1:0]       sat_o
);

    localparam logic signed [buffer_size-1:0] SAT_MAX = buffer_size'((1 << (OUT_W-1)) - 1);
    localparam logic signed [buffer_size-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [buffer_size-1:0] shifted;

    assign shifted = $signed(word_i) >>> shift_i;

    always_comb begin
        sat_o = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_o = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_o = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/noise_stream_reader.sv
// Snapshots the packed noise bus on request and streams one scaled,
// saturated word per neuron over valid/ready, counting rejected requests.
//
//   state     | meaning
//   ST_IDLE   | waiting for sample; snapshot holds the previous capture
//   ST_STREAM | presenting word idx; advances on each handshake
//   ST_DONE   | one-cycle done pulse after the last word was accepted
module noise_stream_reader
    import noise_stream_reader_pkg::*;
#(
    parameter int buffer_size = DEF_BUFFER_SIZE,
    parameter int Num_Neurons = DEF_NUM_NEURONS,
    parameter int OUT_W       = 16,
    parameter int IDX_W       = 4,
    parameter int SHIFT_W     = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [Num_Neurons*buffer_size-1:0] noise_array,
    input  logic                               sample,
    input  logic [SHIFT_W-1:0]                 shift_amt,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_W-1:0]                   out_data,
    output logic [IDX_W-1:0]                   out_idx,
    output logic                               busy,
    output logic                               done,
    output logic [DROP_W-1:0]                  drop_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Num_Neurons - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [buffer_size-1:0] snap_q [Num_Neurons];
    logic [buffer_size-1:0] snap_d [Num_Neurons];
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [DROP_W-1:0]      drop_q, drop_d;
    logic [OUT_W-1:0]       scaled;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            drop_q  <= '0;
            for (int t = 0; t < Num_Neurons; t++) begin
                snap_q[t] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            drop_q  <= drop_d;
            for (int t = 0; t < Num_Neurons; t++) begin
                snap_q[t] <= snap_d[t];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        drop_d  = drop_q;
        for (int t = 0; t < Num_Neurons; t++) begin
            snap_d[t] = snap_q[t];
        end

        case (state_q)
            ST_IDLE: begin
                if (sample) begin
                    for (int t = 0; t < Num_Neurons; t++) begin
                        snap_d[t] = noise_array[t*buffer_size +: buffer_size];
                    end
                    shift_d = shift_amt;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A request in DONE is also rejected: the reader is still busy that cycle.
        if (sample && (state_q != ST_IDLE)) begin
            drop_d = sat_inc(drop_q);
        end
    end

    noise_scale_sat #(
        .buffer_size(buffer_size),
        .OUT_W      (OUT_W),
        .SHIFT_W    (SHIFT_W)
    ) u_scale_sat (
        .word_i (snap_q[idx_q]),
        .shift_i(shift_q),
        .sat_o  (scaled)
    );

    assign out_valid  = (state_q == ST_STREAM);
    assign out_idx    = out_valid ? idx_q : '0;
    assign out_data   = out_valid ? scaled : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign drop_count = drop_q;

endmodule
